sm83_ir: RTL and testbench

- Instruction register and fetch-state tracker for the SM83 core; sits directly upstream of the instruction decoder.
- Latches each fetched opcode byte from the data bus and tracks the CB-prefix bank.
- Manages HALT entry/exit and interrupt-dispatch injection.
- Produces the registered opcode, bank_cb, in_halt and in_alu signals that the decoder consumes.

---
 rtl/sm83_pkg.sv | 16 +
 rtl/sm83_ir_if.sv | 28 ++
 rtl/sm83_opclass.sv | 14 +
 rtl/sm83_ir.sv | 117 +++++++++++
 tb/tb_sm83_ir.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 definitions: data width, special opcodes and the IR fetch-state encoding.
package sm83_pkg;

    localparam int WORD_SIZE = 8;

    localparam logic [WORD_SIZE-1:0] OP_NOP       = 8'h00;
    localparam logic [WORD_SIZE-1:0] OP_HALT      = 8'h76;
    localparam logic [WORD_SIZE-1:0] OP_PREFIX_CB = 8'hCB;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        INT
    } ir_state_t;

endpackage

// File: rtl/sm83_ir_if.sv
// Sequencer <-> instruction register bundle; master is the sequencer/decoder side, slave is sm83_ir.
interface sm83_ir_if;
    import sm83_pkg::*;

    logic [WORD_SIZE-1:0] data_in;
    logic                 ir_load;
    logic                 halt_exec;
    logic                 ime;
    logic                 irq_pending;
    logic                 int_done;
    logic [WORD_SIZE-1:0] opcode;
    logic                 bank_cb;
    logic                 in_halt;
    logic                 in_alu;
    logic                 in_int;
    logic                 pc_inhibit;

    modport master (
        output data_in, ir_load, halt_exec, ime, irq_pending, int_done,
        input  opcode, bank_cb, in_halt, in_alu, in_int, pc_inhibit
    );

    modport slave (
        input  data_in, ir_load, halt_exec, ime, irq_pending, int_done,
        output opcode, bank_cb, in_halt, in_alu, in_int, pc_inhibit
    );

endinterface

// File: rtl/sm83_opclass.sv
// Combinational opcode classifier for unprefixed bytes; shared with the instruction decoder.
module sm83_opclass
    import sm83_pkg::*;
(
    input  logic [WORD_SIZE-1:0] op,
    output logic                 is_alu,
    output logic                 is_prefix_cb
);

    // Register-operand ALU block (10xxxxxx) plus the immediate ALU forms (11xxx110).
    assign is_alu       = (op[7:6] == 2'b10) || (op[7:6] == 2'b11 && op[2:0] == 3'b110);
    assign is_prefix_cb = (op == OP_PREFIX_CB);

endmodule

// File: rtl/sm83_ir.sv
// SM83 instruction register: opcode latch, CB bank tracking, HALT and interrupt injection.
// Build option: define SM83_HALT_BUG_EN to model the HALT bug (PC not incremented after a skipped HALT).
module sm83_ir
    import sm83_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_OPCODE = OP_NOP
) (
    input  logic     clk,
    input  logic     reset_n,
    sm83_ir_if.slave bus
);

    ir_state_t            state;
    logic [WORD_SIZE-1:0] opcode_q;
    logic                 bank_cb_q;
    logic                 in_halt_q;
    logic                 in_alu_q;
    logic                 in_int_q;
    logic                 prefix_q;   // opcode_q is a CB prefix byte, not a CB second byte
    logic                 halt_bug;
    logic                 din_alu;
    logic                 din_cb;
    logic                 take_int;

    sm83_opclass u_opclass (
        .op          (bus.data_in),
        .is_alu      (din_alu),
        .is_prefix_cb(din_cb)
    );

    // The byte after a CB prefix can never be dispatched over.
    assign take_int = bus.ime && bus.irq_pending && !prefix_q;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            opcode_q  <= RESET_OPCODE;
            bank_cb_q <= 1'b0;
            in_halt_q <= 1'b0;
            in_alu_q  <= 1'b0;
            in_int_q  <= 1'b0;
            prefix_q  <= (RESET_OPCODE == OP_PREFIX_CB);
        end else begin
            case (state)
                RUN: begin
                    if (bus.halt_exec) begin
                        if (bus.ime || !bus.irq_pending) begin
                            in_halt_q <= 1'b1;
                            state     <= HALT;
                        end
                    end else if (bus.ir_load) begin
                        if (take_int) begin
                            opcode_q  <= OP_NOP;
                            bank_cb_q <= 1'b0;
                            in_alu_q  <= 1'b0;
                            prefix_q  <= 1'b0;
                            in_int_q  <= 1'b1;
                            state     <= INT;
                        end else begin
                            opcode_q  <= bus.data_in;
                            bank_cb_q <= prefix_q;
                            in_alu_q  <= din_alu && !prefix_q;
                            prefix_q  <= din_cb && !prefix_q;
                        end
                    end
                end
                HALT: begin
                    if (bus.irq_pending) begin
                        in_halt_q <= 1'b0;
                        if (bus.ime) begin
                            opcode_q  <= OP_NOP;
                            bank_cb_q <= 1'b0;
                            in_alu_q  <= 1'b0;
                            prefix_q  <= 1'b0;
                            in_int_q  <= 1'b1;
                            state     <= INT;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                INT: begin
                    if (bus.int_done) begin
                        in_int_q <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef SM83_HALT_BUG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt_bug <= 1'b0;
        end else if (state == RUN) begin
            if (bus.halt_exec) begin
                if (!bus.ime && bus.irq_pending) halt_bug <= 1'b1;
            end else if (bus.ir_load) begin
                halt_bug <= 1'b0;
            end
        end
    end
`else
    assign halt_bug = 1'b0;
`endif

    assign bus.opcode     = opcode_q;
    assign bus.bank_cb    = bank_cb_q;
    assign bus.in_halt    = in_halt_q;
    assign bus.in_alu     = in_alu_q;
    assign bus.in_int     = in_int_q;
    assign bus.pc_inhibit = (state == INT) || (state == RUN && halt_bug);

endmodule

// File: tb/tb_sm83_ir.sv
// Self-checking bench for sm83_ir: directed scenarios followed by random stimulus against a flag-level model.
module tb_sm83_ir;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    // Reference model: what the core is doing, kept as plain flags.
    logic [7:0] m_op;
    bit         m_bank, m_alu, m_halted, m_dispatch, m_bug;

    sm83_ir_if bus ();

    sm83_ir dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit alu_class(input logic [7:0] op);
        int top = int'(op) / 64;
        int low = int'(op) % 8;
        return (top == 2) || (top == 3 && low == 6);
    endfunction

    task automatic model_reset();
        m_op = 8'h00; m_bank = 0; m_alu = 0; m_halted = 0; m_dispatch = 0; m_bug = 0;
    endtask

    task automatic model_enter_int();
        m_dispatch = 1; m_op = 8'h00; m_bank = 0; m_alu = 0;
    endtask

    task automatic model_step(input bit load, input bit halt, input bit ime, input bit irq,
                              input bit done, input logic [7:0] d);
        bit second;
        if (m_dispatch) begin
            if (done) m_dispatch = 0;
        end else if (m_halted) begin
            if (irq) begin
                m_halted = 0;
                if (ime) model_enter_int();
            end
        end else if (halt) begin
            if (!ime && irq) begin
`ifdef SM83_HALT_BUG_EN
                m_bug = 1;
`endif
            end else begin
                m_halted = 1;
            end
        end else if (load) begin
            m_bug = 0;
            second = (m_op == 8'hCB) && !m_bank;
            if (ime && irq && !second) begin
                model_enter_int();
            end else begin
                m_op   = d;
                m_bank = second;
                m_alu  = alu_class(d) && !second;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".opcode"},     bus.opcode,     m_op);
        check({tag, ".bank_cb"},    bus.bank_cb,    m_bank);
        check({tag, ".in_alu"},     bus.in_alu,     m_alu);
        check({tag, ".in_halt"},    bus.in_halt,    m_halted);
        check({tag, ".in_int"},     bus.in_int,     m_dispatch);
        check({tag, ".pc_inhibit"}, bus.pc_inhibit, m_dispatch || m_bug);
    endtask

    // Drive one cycle of sequencer inputs, advance the model and compare after the edge.
    task automatic cyc(input string tag, input bit load, input bit halt, input bit ime,
                       input bit irq, input bit done, input logic [7:0] d);
        bus.ir_load     = load;
        bus.halt_exec   = halt;
        bus.ime         = ime;
        bus.irq_pending = irq;
        bus.int_done    = done;
        bus.data_in     = d;
        model_step(load, halt, ime, irq, done, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.data_in = 8'h3C; bus.ir_load = 0; bus.halt_exec = 0;
        bus.ime = 0; bus.irq_pending = 0; bus.int_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;
        cyc("idle", 0, 0, 0, 0, 0, 8'h3C);
        cyc("load_3c", 1, 0, 0, 0, 0, 8'h3C);
        check("load_3c.direct", bus.opcode, 8'h3C);

        // CB prefix: no interrupt may split the pair
        cyc("load_cb", 1, 0, 0, 0, 0, 8'hCB);
        cyc("load_cb86", 1, 0, 1, 1, 0, 8'h86);
        check("cb86.bank", bus.bank_cb, 1'b1);
        check("cb86.no_int", bus.in_int, 1'b0);

        // Interrupt take on fetch, then dispatch with an ignored load
        cyc("int_take", 1, 0, 1, 1, 0, 8'h80);
        check("int_take.pc_inhibit", bus.pc_inhibit, 1'b1);
        cyc("int_hold", 1, 0, 1, 1, 0, 8'h55);
        cyc("int_done_load", 1, 0, 0, 0, 1, 8'h55);
        cyc("after_int", 0, 0, 0, 0, 0, 8'h00);

        // HALT without ime: wake to RUN, then normal fetch
        cyc("halt_ime0", 0, 1, 0, 0, 0, 8'h76);
        check("halt_ime0.in_halt", bus.in_halt, 1'b1);
        cyc("halt_ignore_load", 1, 1, 0, 0, 0, 8'h11);
        cyc("halt_wake", 0, 0, 0, 1, 0, 8'h00);
        cyc("wake_load", 1, 0, 0, 0, 0, 8'hA7);

        // HALT with ime: wake straight into dispatch
        cyc("halt_ime1", 0, 1, 1, 0, 0, 8'h76);
        cyc("halt_to_int", 0, 0, 1, 1, 0, 8'h00);
        check("halt_to_int.in_int", bus.in_int, 1'b1);
        cyc("halt_int_done", 0, 0, 0, 0, 1, 8'h00);

        // HALT skipped with ime=0 and a pending request
        cyc("halt_bug", 0, 1, 0, 1, 0, 8'h76);
        check("halt_bug.in_halt", bus.in_halt, 1'b0);
        cyc("halt_bug_load", 1, 0, 0, 0, 0, 8'h12);
        cyc("halt_bug_after", 1, 0, 0, 0, 0, 8'h34);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 4,
                8'($urandom));
        end

        // Get into dispatch, then reset asynchronously mid-dispatch
        for (int i = 0; i < 8 && !m_dispatch; i++) begin
            cyc("to_int", !m_halted, 0, 1, 1, 0, 8'h00);
        end
        check("to_int.reached", bus.in_int, 1'b1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("post_reset", 1, 0, 0, 0, 0, 8'h9E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
